// File: rtl/router_pkt_tx_if.sv
// Bundle for router_pkt_tx: upstream FIFO/command side and router-facing byte stream.
interface router_pkt_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       fifo_full;
    logic [6:0] fifo_count;
    logic       cmd_valid;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_corrupt;
    logic       cmd_ready;
    logic       cmd_err;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       tx_done;

    // master: upstream writer plus the router's busy; slave: the transmitter itself
    modport master (
        output wr_en, wr_data, cmd_valid, cmd_addr, cmd_len, cmd_corrupt, busy,
        input  fifo_full, fifo_count, cmd_ready, cmd_err, pkt_valid, data_out, tx_active,
               tx_done
    );

    modport slave (
        input  wr_en, wr_data, cmd_valid, cmd_addr, cmd_len, cmd_corrupt, busy,
        output fifo_full, fifo_count, cmd_ready, cmd_err, pkt_valid, data_out, tx_active,
               tx_done
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for one router input: buffers payload bytes, then frames
// header / payload / parity towards the router, stalling on busy.
module router_pkt_tx #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned IDLE_GAP = 1
) (
    input logic            clk,
    input logic            resetn,
    router_pkt_tx_if.slave bus
);
    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam logic [3:0]  GapLast = (IDLE_GAP == 0) ? 4'd0 : 4'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitData, StHeader, StPayload, StParity, StGap
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q;
    logic [1:0]      addr_q, addr_d;
    logic [5:0]      len_q, len_d;
    logic            corrupt_q, corrupt_d;
    logic [7:0]      parity_q, parity_d;
    logic [5:0]      rem_q, rem_d;
    logic [3:0]      gap_q, gap_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic [7:0]      data_q, data_d;
    logic            cmd_err_q, cmd_err_d;
    logic            tx_done_q, tx_done_d;
    logic            tx_active_q;
    logic            push, pop;

    // A write while full is dropped even when a pop frees a slot in the same cycle.
    assign push    = bus.wr_en && (count_q != CntW'(DEPTH));
    assign count_d = count_q + CntW'(push) - CntW'(pop);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        corrupt_d   = corrupt_q;
        parity_d    = parity_q;
        rem_d       = rem_q;
        gap_d       = gap_q;
        pkt_valid_d = pkt_valid_q;
        data_d      = data_q;
        cmd_err_d   = 1'b0;
        tx_done_d   = 1'b0;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                pkt_valid_d = 1'b0;
                if (bus.cmd_valid) begin
                    if (bus.cmd_addr == 2'd3 || bus.cmd_len == 6'd0) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        addr_d    = bus.cmd_addr;
                        len_d     = bus.cmd_len;
                        corrupt_d = bus.cmd_corrupt;
                        state_d   = StWaitData;
                    end
                end
            end
            StWaitData: begin
                // Whole payload must be buffered so the packet never bubbles.
                if (count_q >= CntW'(len_q)) begin
                    data_d      = {len_q, addr_q};
                    parity_d    = {len_q, addr_q};
                    pkt_valid_d = 1'b1;
                    rem_d       = len_q;
                    state_d     = StHeader;
                end
            end
            StHeader, StPayload: begin
                if (!bus.busy) begin
                    if (rem_q != 6'd0) begin
                        pop      = 1'b1;
                        data_d   = mem[rptr_q];
                        parity_d = parity_q ^ mem[rptr_q];
                        rem_d    = rem_q - 6'd1;
                        state_d  = StPayload;
                    end else begin
                        data_d      = parity_q ^ {8{corrupt_q}};
                        pkt_valid_d = 1'b0;
                        state_d     = StParity;
                    end
                end
            end
            StParity: begin
                if (!bus.busy) begin
                    tx_done_d = 1'b1;
                    data_d    = 8'h00;
                    gap_d     = 4'd0;
                    state_d   = (IDLE_GAP == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            corrupt_q   <= 1'b0;
            parity_q    <= 8'h00;
            rem_q       <= 6'd0;
            gap_q       <= 4'd0;
            pkt_valid_q <= 1'b0;
            data_q      <= 8'h00;
            cmd_err_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_q + PtrW'(push);
            rptr_q      <= rptr_q + PtrW'(pop);
            count_q     <= count_d;
            full_q      <= (count_d == CntW'(DEPTH));
            addr_q      <= addr_d;
            len_q       <= len_d;
            corrupt_q   <= corrupt_d;
            parity_q    <= parity_d;
            rem_q       <= rem_d;
            gap_q       <= gap_d;
            pkt_valid_q <= pkt_valid_d;
            data_q      <= data_d;
            cmd_err_q   <= cmd_err_d;
            tx_done_q   <= tx_done_d;
            tx_active_q <= (state_d != StIdle);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= bus.wr_data;
        end
    end

    assign bus.fifo_full  = full_q;
    assign bus.fifo_count = 7'(count_q);
    assign bus.cmd_ready  = (state_q == StIdle);
    assign bus.cmd_err    = cmd_err_q;
    assign bus.pkt_valid  = pkt_valid_q;
    assign bus.data_out   = data_q;
    assign bus.tx_active  = tx_active_q;
    assign bus.tx_done    = tx_done_q;
endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for one router input port. It drives pkt_valid and data_in into the router and honours the router's busy.
- Upstream logic writes payload bytes into an internal byte FIFO and then issues a send command with destination address and length.
- The block frames the packet as header, payload, then parity, with no payload bubbles.
- Used as the traffic generator and CPU-side transmitter in front of the 1x3 router.

Parameters:
DEPTH, 64, payload FIFO depth in bytes; must be >= 63 and a power of 2.
IDLE_GAP, 1, minimum cycles with pkt_valid=0 after a parity byte is accepted (0..15).

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
wr_en  input  1  payload FIFO write strobe
wr_data  input  8  payload byte
fifo_full  output  1  FIFO holds DEPTH bytes
fifo_count  output  7  bytes currently buffered
cmd_valid  input  1  send request
cmd_addr  input  2  destination port 0..2
cmd_len  input  6  payload length 1..63
cmd_corrupt  input  1  invert parity byte of this packet (error injection)
cmd_ready  output  1  command accepted this cycle if cmd_valid
cmd_err  output  1  1-cycle pulse: invalid command dropped
busy  input  1  router busy; byte on data_out is accepted at a rising edge where busy=0
pkt_valid  output  1  to router pkt_valid
data_out  output  8  to router data_in
tx_active  output  1  state is not IDLE
tx_done  output  1  1-cycle pulse after the parity byte is accepted

Behaviour:
- Reset (resetn=0 at an edge): state IDLE; FIFO emptied (pointers and count 0).
  - pkt_valid=0, data_out=0, cmd_err=0, tx_done=0, tx_active=0.
  - Latched cmd fields, parity accumulator and remaining counter cleared.
  - Reset mid-packet abandons the packet; pkt_valid is 0 from the next cycle.
- All outputs are registered except cmd_ready, which equals (state==IDLE).
- FIFO:
  - A write occurs at an edge with wr_en=1 and count<DEPTH.
  - A write when full is ignored, even if a pop occurs in the same cycle.
  - Simultaneous write and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Accept rule: a byte is "accepted" at a rising edge where busy=0. Otherwise data_out and pkt_valid hold unchanged.
- States: IDLE, WAIT_DATA, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: pkt_valid=0. On cmd_valid:
  - If cmd_addr==3 or cmd_len==0: cmd_err=1 the next cycle, stay IDLE.
  - Else latch addr, len and corrupt, and go to WAIT_DATA.
- WAIT_DATA: wait until fifo_count >= len_r. Then at that edge:
  - data_out <= {len_r, addr_r}, pkt_valid <= 1.
  - parity <= {len_r, addr_r}, rem <= len_r, go to HEADER.
  - The FIFO guarantees no bubble once the header is out.
- HEADER/PAYLOAD, on accept:
  - If rem>0: pop FIFO head into data_out, parity ^= byte, rem--, state PAYLOAD, pkt_valid stays 1.
  - If rem==0 (last payload byte accepted): data_out <= parity XOR (corrupt_r ? 8'hFF : 8'h00), pkt_valid <= 0, go to PARITY.
- PARITY: hold data_out=parity and pkt_valid=0 until accepted. Then tx_done=1 for one cycle, data_out <= 0, go to GAP.
- GAP: IDLE_GAP cycles with pkt_valid=0, then IDLE. IDLE_GAP=0 goes directly to IDLE.
- Parity is the XOR of the header and all payload bytes.
- One FIFO pop per accepted payload byte. Bytes beyond len stay buffered for the next packet.
- busy may stay high indefinitely; the block has no timeout.
- FIFO writes are allowed in every state, including during transmission.

Test Plan:
1. Write 0x11,0x22,0x33; cmd addr=1 len=3, busy=0 -> data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0; tx_done pulses; fifo_count ends at 0.
2. Same packet, busy=1 for 2 cycles after header accepted (router LFD) -> byte 0x11 held for 3 cycles, no extra pop; busy=1 during parity -> parity 0x0D held, tx_done only after busy=0.
3. Buffer 2 bytes, cmd len=4 -> WAIT_DATA, pkt_valid=0, tx_active=1; write 2 more bytes -> header 0x10 appears the cycle after count reaches 4.
4. cmd addr=3 len=5 -> cmd_err pulse, pkt_valid never rises. cmd addr=0 len=0 -> cmd_err.
5. Test 1 with cmd_corrupt=1 -> parity byte 0xF2; the next packet with corrupt=0 sends correct parity.
6. 64 writes -> fifo_full=1, count=64; 65th write ignored. Reset asserted mid-payload -> pkt_valid=0, fifo_count=0, state IDLE next cycle.
